hs_dma_arb: RTL and testbench



---
 rtl/hs_dma_arb.sv | 181 ++++++++++++++++++
 tb/tb_hs_dma_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_dma_arb.sv
// hs_dma_arb: two-requester round-robin DMA command arbiter.
// Requester 0 is the DCR register path, requester 1 the hardware command
// sequencer. The winning descriptor is latched onto the dma_* interface,
// dma_req is held until dma_ack, and a watchdog aborts a transfer that the
// engine never accepts.
module hs_dma_arb #(
  parameter int unsigned C_TIMEOUT = 4096,
  parameter int unsigned C_TO_W    = 13
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  // requester 0
  input  logic        r0_req,
  input  logic [31:0] r0_address,
  input  logic [15:0] r0_length,
  input  logic [10:0] r0_ctl,
  output logic        r0_gnt,
  output logic        r0_done,
  output logic        r0_err,
  // requester 1
  input  logic        r1_req,
  input  logic [31:0] r1_address,
  input  logic [15:0] r1_length,
  input  logic [10:0] r1_ctl,
  output logic        r1_gnt,
  output logic        r1_done,
  output logic        r1_err,
  // DMA engine request interface
  output logic [31:0] dma_address,
  output logic [15:0] dma_length,
  output logic [3:0]  dma_pm,
  output logic        dma_sof,
  output logic        dma_eof,
  output logic        dma_flush,
  output logic        dma_sync,
  output logic        dma_wrt,
  output logic        dma_data,
  output logic        dma_ok,
  output logic        dma_req,
  input  logic        dma_ack,
  // status
  output logic        busy,
  output logic        owner,
  output logic        to_err,
  input  logic        to_clr
);

  // A zero timeout disables the watchdog entirely. TO_LAST is the counter
  // value of the final cycle dma_req may stay high without an ack.
  localparam bit                TO_EN   = (C_TIMEOUT != 0);
  localparam logic [C_TO_W-1:0] TO_LAST = TO_EN ? C_TO_W'(C_TIMEOUT - 1) : '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic [10:0] ctl;
  } desc_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [C_TO_W-1:0] cnt_q, cnt_d;
  logic              req_q, req_d;
  desc_t             desc_q, desc_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              to_err_q, to_err_d;

  desc_t r0_desc, r1_desc;
  logic  any_req;
  logic  win;

  assign r0_desc = '{addr: r0_address, len: r0_length, ctl: r0_ctl};
  assign r1_desc = '{addr: r1_address, len: r1_length, ctl: r1_ctl};
  assign any_req = r0_req | r1_req;
  // r1 wins when it is alone, or when both request and r0 went last.
  assign win     = r1_req & (~r0_req | ~last_q);

  // Next-state and next-output logic for the IDLE/WAIT arbiter.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    desc_d   = desc_q;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = '0;
    to_err_d = to_err_q & ~to_clr;

    unique case (state_q)
      S_IDLE: begin
        // dma_ack is deliberately ignored here; only requests matter.
        if (any_req) begin
          desc_d     = win ? r1_desc : r0_desc;
          gnt_d[win] = 1'b1;
          req_d      = 1'b1;
          cnt_d      = '0;
          owner_d    = win;
          last_d     = win;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dma_ack) begin
          // Ack has priority over a watchdog expiry in the same cycle.
          req_d           = 1'b0;
          done_d[owner_q] = 1'b1;
          state_d         = S_IDLE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // A new timeout overrides a simultaneous to_clr.
          req_d          = 1'b0;
          err_d[owner_q] = 1'b1;
          to_err_d       = 1'b1;
          state_d        = S_IDLE;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops dma_req without any pulse.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      desc_q   <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      to_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      desc_q   <= desc_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      to_err_q <= to_err_d;
    end
  end

  assign r0_gnt      = gnt_q[0];
  assign r1_gnt      = gnt_q[1];
  assign r0_done     = done_q[0];
  assign r1_done     = done_q[1];
  assign r0_err      = err_q[0];
  assign r1_err      = err_q[1];

  assign dma_address = desc_q.addr;
  assign dma_length  = desc_q.len;
  assign dma_pm      = desc_q.ctl[3:0];
  assign dma_sof     = desc_q.ctl[4];
  assign dma_eof     = desc_q.ctl[5];
  assign dma_flush   = desc_q.ctl[6];
  assign dma_sync    = desc_q.ctl[7];
  assign dma_wrt     = desc_q.ctl[8];
  assign dma_data    = desc_q.ctl[9];
  assign dma_ok      = desc_q.ctl[10];
  assign dma_req     = req_q;

  assign busy        = req_q;
  assign owner       = owner_q;
  assign to_err      = to_err_q;

endmodule

// File: tb/tb_hs_dma_arb.sv
// Bench for hs_dma_arb: transaction-level reference model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_hs_dma_arb;
  localparam int TO = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        r0_req, r1_req;
  logic [31:0] r0_address, r1_address;
  logic [15:0] r0_length, r1_length;
  logic [10:0] r0_ctl, r1_ctl;
  logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
  logic [31:0] dma_address;
  logic [15:0] dma_length;
  logic [3:0]  dma_pm;
  logic        dma_sof, dma_eof, dma_flush, dma_sync, dma_wrt, dma_data, dma_ok;
  logic        dma_req, dma_ack, busy, owner, to_err, to_clr;

  int checks = 0;
  int errors = 0;

  hs_dma_arb #(.C_TIMEOUT(TO), .C_TO_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .r0_req(r0_req), .r0_address(r0_address), .r0_length(r0_length), .r0_ctl(r0_ctl),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_address(r1_address), .r1_length(r1_length), .r1_ctl(r1_ctl),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err),
    .dma_address(dma_address), .dma_length(dma_length), .dma_pm(dma_pm),
    .dma_sof(dma_sof), .dma_eof(dma_eof), .dma_flush(dma_flush), .dma_sync(dma_sync),
    .dma_wrt(dma_wrt), .dma_data(dma_data), .dma_ok(dma_ok),
    .dma_req(dma_req), .dma_ack(dma_ack),
    .busy(busy), .owner(owner), .to_err(to_err), .to_clr(to_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Reference model: a transfer is either in flight or not; m_hi is the
  // 1-based index of the current dma_req-high cycle.
  bit          mv = 1'b0;
  bit          m_active, m_last, m_owner, m_to_err, m_w, m_tout;
  int          m_hi;
  logic [31:0] m_addr;
  logic [15:0] m_len;
  logic [10:0] m_ctl;
  logic [1:0]  m_gnt, m_done, m_err;

  // Compare outputs of the last edge, then step the model with the inputs
  // the next edge will sample.
  always @(negedge sys_clk) begin
    if (mv) begin
      chk("cmp_dma_req", dma_req, m_active);
      chk("cmp_busy", busy, m_active);
      chk("cmp_owner", owner, m_owner);
      chk("cmp_to_err", to_err, m_to_err);
      chk("cmp_gnt", {r1_gnt, r0_gnt}, m_gnt);
      chk("cmp_done", {r1_done, r0_done}, m_done);
      chk("cmp_err", {r1_err, r0_err}, m_err);
      chk("cmp_addr", dma_address, m_addr);
      chk("cmp_len", dma_length, m_len);
      chk("cmp_ctl", {dma_ok, dma_data, dma_wrt, dma_sync, dma_flush, dma_eof, dma_sof, dma_pm}, m_ctl);
    end
    m_gnt = '0; m_done = '0; m_err = '0;
    if (sys_rst) begin
      m_active = 0; m_last = 1; m_owner = 0; m_to_err = 0; m_hi = 0;
      m_addr = '0; m_len = '0; m_ctl = '0;
      mv = 1'b1;
    end else begin
      m_tout = 0;
      if (!m_active) begin
        if (r0_req || r1_req) begin
          m_w = (r0_req && r1_req) ? !m_last : r1_req;
          m_addr = m_w ? r1_address : r0_address;
          m_len  = m_w ? r1_length  : r0_length;
          m_ctl  = m_w ? r1_ctl     : r0_ctl;
          m_gnt[m_w] = 1'b1;
          m_active = 1; m_hi = 1; m_last = m_w; m_owner = m_w;
        end
      end else if (dma_ack) begin
        m_active = 0;
        m_done[m_owner] = 1'b1;
      end else if (m_hi == TO) begin
        m_active = 0;
        m_err[m_owner] = 1'b1;
        m_tout = 1;
      end else begin
        m_hi++;
      end
      if (m_tout) m_to_err = 1;
      else if (to_clr) m_to_err = 0;
    end
  end

  int hi, errs, dones, n_g;
  int g_who[4], g_at[4];

  initial begin
    sys_rst = 1; r0_req = 0; r1_req = 0; dma_ack = 0; to_clr = 0;
    r0_address = 32'h1000_0040; r0_length = 16'h0200; r0_ctl = 11'h30F;
    r1_address = 32'h2000_0080; r1_length = 16'h0044; r1_ctl = 11'h4B2;
    cyc(3);
    chk("rst_dma_req", dma_req, 0);
    chk("rst_owner", owner, 0);
    chk("rst_to_err", to_err, 0);
    chk("rst_addr", dma_address, 0);
    sys_rst = 0;

    // Single r0 descriptor, ack three cycles after dma_req.
    r0_req = 1;
    cyc(1);
    chk("t1_r0_gnt", r0_gnt, 1);
    chk("t1_dma_req", dma_req, 1);
    chk("t1_addr", dma_address, 32'h1000_0040);
    chk("t1_len", dma_length, 16'h0200);
    chk("t1_pm", dma_pm, 4'hF);
    chk("t1_sof", dma_sof, 0);
    chk("t1_wrt", dma_wrt, 1);
    chk("t1_data", dma_data, 1);
    r0_req = 0;
    cyc(3);
    dma_ack = 1;
    cyc(1);
    dma_ack = 0;
    chk("t1_r0_done", r0_done, 1);
    chk("t1_req_low", dma_req, 0);
    chk("t1_owner", owner, 0);
    cyc(1);

    // Both requesting continuously with immediate ack: alternation.
    sys_rst = 1;
    cyc(1);
    sys_rst = 0; r0_req = 1; r1_req = 1; dma_ack = 1;
    n_g = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("t2_req_gap", dma_req, (i % 2 == 0));
      if (r0_gnt || r1_gnt) begin
        if (n_g < 4) begin
          g_who[n_g] = r1_gnt;
          g_at[n_g] = i;
        end
        n_g++;
      end
    end
    r0_req = 0; r1_req = 0; dma_ack = 0;
    chk("t2_ngnt", n_g, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", g_who[k], k % 2);
      chk("t2_spacing", g_at[k], 2 * k);
    end
    cyc(1);

    // r1 with no ack: watchdog abort.
    r1_req = 1;
    cyc(1);
    r1_req = 0;
    hi = 1; errs = 0; dones = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      hi += int'(dma_req);
      errs += int'(r1_err);
      dones += int'(r1_done);
    end
    chk("t3_hi_cycles", hi, 8);
    chk("t3_r1_err", errs, 1);
    chk("t3_no_done", dones, 0);
    chk("t3_to_err_sticky", to_err, 1);
    to_clr = 1;
    cyc(1);
    to_clr = 0;
    chk("t3_to_clr", to_err, 0);

    // Ack on exactly the last permitted cycle.
    r0_req = 1;
    cyc(1);
    r0_req = 0;
    cyc(TO - 1);
    dma_ack = 1;
    cyc(1);
    dma_ack = 0;
    chk("t4_r0_done", r0_done, 1);
    chk("t4_r0_err", r0_err, 0);
    chk("t4_to_err", to_err, 0);

    // Timeout with to_clr in the same cycle: the set wins.
    r1_req = 1;
    cyc(1);
    r1_req = 0;
    cyc(TO - 1);
    to_clr = 1;
    cyc(1);
    to_clr = 0;
    chk("t4_set_wins", to_err, 1);
    chk("t4_r1_err", r1_err, 1);
    to_clr = 1;
    cyc(1);
    to_clr = 0;

    // Reset two cycles into WAIT, then contention goes to r0.
    r0_req = 1;
    cyc(1);
    r0_req = 0;
    cyc(1);
    sys_rst = 1;
    cyc(1);
    chk("t5_req_drop", dma_req, 0);
    chk("t5_no_pulse", {r0_done, r0_err, r1_done, r1_err}, 0);
    sys_rst = 0; r0_req = 1; r1_req = 1;
    cyc(1);
    chk("t5_r0_first", {r1_gnt, r0_gnt}, 2'b01);
    r0_req = 0; dma_ack = 1;
    cyc(1);
    dma_ack = 0;
    cyc(1);
    chk("t5_r1_next", r1_gnt, 1);
    r1_req = 0; dma_ack = 1;
    cyc(1);
    dma_ack = 0;

    // Spurious ack in IDLE; r1 raised during an r0 transfer.
    dma_ack = 1;
    cyc(2);
    dma_ack = 0;
    chk("t6_spurious", {r0_done, r1_done, r0_err, r1_err}, 0);
    r0_req = 1;
    cyc(1);
    r0_req = 0;
    cyc(1);
    r1_req = 1;
    cyc(2);
    chk("t6_r1_waits", r1_gnt, 0);
    dma_ack = 1;
    cyc(1);
    dma_ack = 0;
    chk("t6_r0_done", r0_done, 1);
    chk("t6_no_gnt_yet", r1_gnt, 0);
    cyc(1);
    chk("t6_r1_gnt", r1_gnt, 1);
    r1_req = 0; dma_ack = 1;
    cyc(1);
    dma_ack = 0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
